// File: rtl/sdiff_integrator.sv
// Purpose    : signed running-sum integrator; rebuilds a value stream from its difference stream.
// Latency    : 1 cycle from an accepted diff to its sum on the registered output.
// Backpressure: in_ready drops while a result is pending and out_ready is low; sum is held stable.
//
// Ports:
//   Clk / Rst        rising-edge clock, asynchronous active-low reset
//   clr              synchronous clear (acc, pending output, ovf, cnt); wins over any accept
//   in_valid/in_ready/diff    signed difference input, valid/ready handshake
//   out_valid/out_ready/sum   signed running-sum output, valid/ready handshake
//   ovf              sticky overflow flag since last reset/clr
//   cnt              accepted-sample counter, wraps at 2^CNTW
module sdiff_integrator #(
    parameter int                            DATAWIDTH = 64,
    parameter bit                            SATURATE  = 1'b0,
    parameter logic signed [DATAWIDTH-1:0]   INIT      = '0,
    parameter int                            CNTW      = 16
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        clr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATAWIDTH-1:0] diff,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATAWIDTH-1:0] sum,
    output logic                        ovf,
    output logic [CNTW-1:0]             cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ostate_t;

    localparam logic signed [DATAWIDTH-1:0] SMAX = {1'b0, {(DATAWIDTH-1){1'b1}}};
    localparam logic signed [DATAWIDTH-1:0] SMIN = {1'b1, {(DATAWIDTH-1){1'b0}}};

    ostate_t                      state;
    ostate_t                      state_nxt;
    logic signed [DATAWIDTH-1:0]  acc;
    logic signed [DATAWIDTH-1:0]  acc_nxt;
    logic        [DATAWIDTH:0]    t;
    logic                         ovf_now;
    logic                         accept;

    assign out_valid = (state == FULL);

    // Ready depends only on reset, clear and the output slot; never on in_valid.
    assign in_ready = Rst & ~clr & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // One guard bit above the data width exposes signed overflow as a
    // disagreement between the top two bits of the widened sum.
    assign t       = {acc[DATAWIDTH-1], acc} + {diff[DATAWIDTH-1], diff};
    assign ovf_now = t[DATAWIDTH] ^ t[DATAWIDTH-1];

    always_comb begin
        acc_nxt = t[DATAWIDTH-1:0];
        if (SATURATE && ovf_now) begin
            // The guard bit carries the true sign of the unclamped result.
            acc_nxt = t[DATAWIDTH] ? SMIN : SMAX;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = FULL;
                FULL:  if (out_ready && !accept) state_nxt = EMPTY;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= EMPTY;
            acc   <= INIT;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                acc <= INIT;
                ovf <= 1'b0;
                cnt <= '0;
            end else if (accept) begin
                acc <= acc_nxt;
                ovf <= ovf | ovf_now;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The accumulator only moves on accept, so it always equals the last
    // delivered or pending result and doubles as the registered output.
    assign sum = acc;

endmodule
